// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with flush and free-space count.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] space_o
);

  fetch_entry_t  mem_q [FIFO_DEPTH];
  fetch_entry_t  mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_eff, pop_eff;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign space_o = CW'(FIFO_DEPTH) - count_q;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    push_eff = push_i && (!full_o || pop_i) && !flush_i;
    pop_eff  = pop_i && !empty_o && !flush_i;
    mem_d    = mem_q;
    if (push_eff) mem_d[wptr_q] = entry_i;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + PW'(push_eff);
      rptr_d  = rptr_q + PW'(pop_eff);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory fetch into a FIFO feeding decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        req_dec_o,
  input  logic        ack_dec_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] pc_o,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          discard_q, discard_d;
  logic          push, pop, rsp_valid, space_ok;
  fetch_entry_t  rsp_entry, fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_space;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i (rsp_entry),
    .pop_i   (pop),
    .flush_i (jump_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .space_o (fifo_space)
  );

  assign instr_req_o  = (state_q == REQ);
  assign instr_addr_o = pc_q;

  // The only in-flight request was issued at pc_q - 4, since a redirect while waiting sets discard.
  assign rsp_entry = '{pc: pc_q - 32'd4, instr: instr_rdata_i};
  assign rsp_valid = (state_q == WAIT) && instr_rvalid_i && !discard_q && !jump_i;

  always_comb begin
`ifdef FETCH_BYPASS_EN
    req_dec_o     = !fifo_empty || rsp_valid;
    instr_rdata_o = !fifo_empty ? fifo_head.instr : (rsp_valid ? rsp_entry.instr : INSTR_NOP);
    pc_o          = !fifo_empty ? fifo_head.pc : (rsp_valid ? rsp_entry.pc : 32'd0);
    push          = rsp_valid && !(fifo_empty && ack_dec_i);
    pop           = !fifo_empty && ack_dec_i && !jump_i;
`else
    req_dec_o     = !fifo_empty;
    instr_rdata_o = fifo_empty ? INSTR_NOP : fifo_head.instr;
    pc_o          = fifo_empty ? 32'd0 : fifo_head.pc;
    push          = rsp_valid;
    pop           = req_dec_o && ack_dec_i && !jump_i;
`endif
  end

  // Free slots once this cycle's push/pop settle; nothing is outstanding when this is consulted.
  assign space_ok = (CW1'(fifo_space) + CW1'(pop)) > CW1'(push);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if (jump_i) pc_d = word_align(jump_target_i);
    case (state_q)
      IDLE: if (jump_i || space_ok) state_d = REQ;
      REQ: begin
        if (instr_gnt_i) begin
          state_d = WAIT;
          if (jump_i) discard_d = 1'b1;
          else        pc_d      = pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (instr_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = (jump_i || space_ok) ? REQ : IDLE;
        end else if (jump_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= BOOT_ADDR;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: streaming table, back-pressure, redirects, reset mid-fetch.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        req_dec_o;
  logic        ack_dec_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] pc_o;
  logic        jump_i;
  logic [31:0] jump_target_i;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  fetch_stage #(.BOOT_ADDR(32'h0000_0080), .FIFO_DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .req_dec_o      (req_dec_o),
    .ack_dec_i      (ack_dec_i),
    .instr_rdata_o  (instr_rdata_o),
    .pc_o           (pc_o),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!instr_req_o && n < 20) begin
      tick();
      n++;
    end
    check("req_wait", 32'(instr_req_o), 32'd1);
  endtask

  // Grant the pending request, answer it one cycle later, record the expected entry.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata);
    check("fetch_addr", instr_addr_o, addr);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    check("req_low_in_wait", 32'(instr_req_o), 32'd0);
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = rdata;
    sb.push_back('{pc: addr, instr: rdata});
    tick();
    instr_rvalid_i = 1'b0;
  endtask

  task automatic consume();
    exp_t e;
    check("dec_valid", 32'(req_dec_o), 32'd1);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_underflow: got output, expected none");
    end else begin
      e = sb.pop_front();
      check("dec_pc", pc_o, e.pc);
      check("dec_instr", instr_rdata_o, e.instr);
    end
    ack_dec_i = 1'b1;
    tick();
    ack_dec_i = 1'b0;
  endtask

  task automatic check_empty_out(input string name);
    check({name, "_req_dec"}, 32'(req_dec_o), 32'd0);
    check({name, "_instr"}, instr_rdata_o, 32'h0000_0013);
    check({name, "_pc"}, pc_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{addr: 32'h0000_0080, rdata: 32'h0050_0093};
    tbl[1] = '{addr: 32'h0000_0084, rdata: 32'h0010_8113};
    tbl[2] = '{addr: 32'h0000_0088, rdata: 32'h0020_81b3};
    tbl[3] = '{addr: 32'h0000_008c, rdata: 32'hfff0_0213};

    rst_ni = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    ack_dec_i = 1'b0; jump_i = 1'b0; jump_target_i = '0;
    tick();
    tick();
    check("rst_req", 32'(instr_req_o), 32'd0);
    check("rst_addr", instr_addr_o, 32'h0000_0080);
    check_empty_out("rst");

    // Streaming fetch with immediate grants and decode consuming each word.
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      do_fetch(tbl[i].addr, tbl[i].rdata);
      consume();
    end

    // Back-pressure: two words fill the FIFO, requests stop until one is consumed.
    wait_req();
    do_fetch(32'h0000_0090, 32'h1111_1111);
    do_fetch(32'h0000_0094, 32'h2222_2222);
    for (int i = 0; i < 3; i++) begin
      check("full_no_req", 32'(instr_req_o), 32'd0);
      tick();
    end
    consume();
    check("req_after_ack", 32'(instr_req_o), 32'd1);
    do_fetch(32'h0000_0098, 32'h3333_3333);
    consume();
    consume();

    // Redirect while waiting: the in-flight response is discarded.
    wait_req();
    check("pre_jump_addr", instr_addr_o, 32'h0000_009c);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    jump_i = 1'b1; jump_target_i = 32'h0000_0200;
    tick();
    jump_i = 1'b0;
    check_empty_out("jump_wait");
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hdead_beef;
    tick();
    instr_rvalid_i = 1'b0;
    check_empty_out("dropped_rsp");
    check("jump_req", 32'(instr_req_o), 32'd1);
    do_fetch(32'h0000_0200, 32'h1234_5678);
    consume();

    // Full FIFO flushed by a redirect that coincides with an ack.
    do_fetch(32'h0000_0204, 32'haaaa_aaaa);
    do_fetch(32'h0000_0208, 32'hbbbb_bbbb);
    jump_i = 1'b1; jump_target_i = 32'h0000_0300; ack_dec_i = 1'b1;
    tick();
    jump_i = 1'b0; ack_dec_i = 1'b0;
    sb.delete();
    check_empty_out("flush_full");
    check("flush_req", 32'(instr_req_o), 32'd1);
    check("flush_addr", instr_addr_o, 32'h0000_0300);

    // Redirects in REQ without grant: alignment and wrap of the fetch PC.
    jump_i = 1'b1; jump_target_i = 32'h0000_0203;
    tick();
    check("align_addr", instr_addr_o, 32'h0000_0200);
    check("align_req", 32'(instr_req_o), 32'd1);
    jump_target_i = 32'hffff_fffc;
    tick();
    jump_i = 1'b0;
    do_fetch(32'hffff_fffc, 32'h0000_0073);
    check("wrap_addr", instr_addr_o, 32'h0000_0000);
    consume();

    // Redirect in the same cycle as a grant: that response must be dropped.
    jump_i = 1'b1; jump_target_i = 32'h0000_0400; instr_gnt_i = 1'b1;
    tick();
    jump_i = 1'b0; instr_gnt_i = 1'b0;
    check("gnt_jump_wait", 32'(instr_req_o), 32'd0);
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hcafe_f00d;
    tick();
    instr_rvalid_i = 1'b0;
    check_empty_out("gnt_jump_drop");
    check("gnt_jump_addr", instr_addr_o, 32'h0000_0400);

    // Reset while waiting; a stale response after release is ignored.
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst2_req", 32'(instr_req_o), 32'd0);
    check("rst2_addr", instr_addr_o, 32'h0000_0080);
    check_empty_out("rst2");
    tick();
    rst_ni = 1'b1;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hbad0_bad0;
    tick();
    instr_rvalid_i = 1'b0;
    check_empty_out("stale_rsp");
    wait_req();
    do_fetch(32'h0000_0080, 32'h0050_0093);
    consume();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
